// File: rtl/mem_access_unit_pkg.sv
// mem_pkg: shared funct3 codes, byte-enable masks, FSM states and access-size decode for the load/store unit.
package mem_pkg;
  localparam logic [2:0] F3_LB = 3'b000;
  localparam logic [2:0] F3_LH = 3'b001;
  localparam logic [2:0] F3_LW = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} mau_state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_t;
  // Stores only know sb/sh/sw; loads also size their unsigned variants.
  function automatic acc_size_t accessSize(input logic [2:0] funct3, input logic isStore);
    if (isStore)
      return funct3 == F3_SB ? SZ_BYTE : funct3 == F3_SH ? SZ_HALF : SZ_WORD;
    return (funct3 == F3_LB || funct3 == F3_LBU) ? SZ_BYTE :
           (funct3 == F3_LH || funct3 == F3_LHU) ? SZ_HALF : SZ_WORD;
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: req/gnt/rvalid data-bus bundle between the load/store unit and memory.
interface mem_access_unit_if #(parameter int XLEN = 32);
  logic bus_req;
  logic bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [3:0] bus_be;
  logic [XLEN-1:0] bus_wdata;
  logic bus_gnt;
  logic bus_rvalid;
  logic [XLEN-1:0] bus_rdata;
  modport master(output bus_req, bus_we, bus_addr, bus_be, bus_wdata, input bus_gnt, bus_rvalid, bus_rdata);
  modport slave(input bus_req, bus_we, bus_addr, bus_be, bus_wdata, output bus_gnt, bus_rvalid, bus_rdata);
endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// load_formatter: extracts and sign/zero-extends the addressed byte or half of a read word.
module load_formatter
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  output logic [31:0] result
);
  logic [7:0] byteSel;
  logic [15:0] halfSel;
  assign byteSel = rdata[8*lane +: 8];
  assign halfSel = lane[1] ? rdata[31:16] : rdata[15:0];
  always_comb
    result = funct3 == F3_LB  ? {{24{byteSel[7]}}, byteSel} :
             funct3 == F3_LBU ? {24'b0, byteSel} :
             funct3 == F3_LH  ? {{16{halfSel[15]}}, halfSel} :
             funct3 == F3_LHU ? {16'b0, halfSel} : rdata;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store unit driving a req/gnt/rvalid bus and stalling the pipeline.
// MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of forcing natural alignment.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_RDATA = 32'h0
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [2:0]      Funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  mem_access_unit_if.master bus,
  output logic [XLEN-1:0] ReadDataM,
  output logic            StallM,
  output logic            MisalignM
);
  mau_state_t state, nextState;
  acc_size_t size;
  logic access, isStore, misaligned;
  logic [3:0] curBe, reqBe;
  logic [XLEN-1:0] curAddr, curWdata, reqAddr, reqWdata, holdData, loadResult;
  logic reqWe;
  logic [2:0] reqFunct3;
  logic [1:0] reqLane;
  // Gated by reset so the combinational request cannot escape while the unit is held in reset.
  assign access = RST_N & (MemReadM | MemWriteM);
  assign isStore = MemWriteM;
  assign size = accessSize(Funct3M, isStore);
  assign curAddr = {ALUResultM[XLEN-1:2], 2'b00};
  always_comb begin
    curBe = size == SZ_BYTE ? BE_BYTE << ALUResultM[1:0] :
            size == SZ_HALF ? BE_HALF << {ALUResultM[1], 1'b0} : BE_WORD;
    curWdata = size == SZ_BYTE ? {4{WriteDataM[7:0]}} :
               size == SZ_HALF ? {2{WriteDataM[15:0]}} : WriteDataM;
  end
`ifdef MISALIGN_TRAP_EN
  assign misaligned = (size == SZ_HALF && ALUResultM[0]) || (size == SZ_WORD && |ALUResultM[1:0]);
`else
  assign misaligned = 1'b0;
`endif
  always_comb begin
    nextState = state;
    StallM = 1'b0;
    bus.bus_req = 1'b0;
    bus.bus_we = reqWe;
    bus.bus_addr = reqAddr;
    bus.bus_be = reqBe;
    bus.bus_wdata = reqWdata;
    case (state)
      IDLE: begin
        StallM = access;
        bus.bus_req = access & ~misaligned;
        bus.bus_we = isStore;
        bus.bus_addr = curAddr;
        bus.bus_be = curBe;
        bus.bus_wdata = curWdata;
        nextState = !access ? IDLE : misaligned ? DONE : !bus.bus_gnt ? REQ : isStore ? DONE : WAIT_RSP;
      end
      REQ: begin
        StallM = 1'b1;
        bus.bus_req = 1'b1;
        nextState = !bus.bus_gnt ? REQ : reqWe ? DONE : WAIT_RSP;
      end
      WAIT_RSP: begin
        StallM = 1'b1;
        nextState = bus.bus_rvalid ? DONE : WAIT_RSP;
      end
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      reqWe <= 1'b0;
      reqAddr <= '0;
      reqBe <= '0;
      reqWdata <= '0;
      reqFunct3 <= '0;
      reqLane <= '0;
      holdData <= RESET_RDATA;
    end else begin
      state <= nextState;
      if (state == IDLE && access) begin
        reqWe <= isStore;
        reqAddr <= curAddr;
        reqBe <= curBe;
        reqWdata <= curWdata;
        reqFunct3 <= Funct3M;
        reqLane <= ALUResultM[1:0];
      end
      if (state == WAIT_RSP && bus.bus_rvalid)
        holdData <= loadResult;
      else if (state == IDLE && access && misaligned)
        holdData <= '0;
    end
`ifdef MISALIGN_TRAP_EN
  logic misReg;
  // Only the IDLE->DONE trap path sets this, so it is high exactly in that DONE cycle.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N)
      misReg <= 1'b0;
    else
      misReg <= state == IDLE && access && misaligned;
  assign MisalignM = misReg;
`else
  assign MisalignM = 1'b0;
`endif
  assign ReadDataM = holdData;
  load_formatter uFormatter (
    .funct3(reqFunct3),
    .lane  (reqLane),
    .rdata (bus.bus_rdata),
    .result(loadResult)
  );
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed plus randomized accesses checked each cycle against a transaction-level model.
module tb_mem_access_unit;
  logic CLK, RST_N, MemReadM, MemWriteM, StallM, MisalignM;
  logic [2:0] Funct3M;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  mem_access_unit_if bus();
  mem_access_unit dut (
    .CLK(CLK), .RST_N(RST_N), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .bus(bus),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM)
  );
  int tests = 0, fails = 0, stallCnt = 0, reqCnt = 0, nsCnt = 0;
  logic chk = 0;
  logic exp_req, exp_stall, exp_mis, exp_we;
  logic [3:0] exp_be;
  logic [31:0] exp_rd, exp_addr, exp_wdata, hold;
  initial CLK = 0;
  always #5 CLK = ~CLK;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge CLK) if (chk) begin
    check("StallM", StallM, exp_stall);
    check("bus_req", bus.bus_req, exp_req);
    check("ReadDataM", ReadDataM, exp_rd);
    check("MisalignM", MisalignM, exp_mis);
    if (exp_req) begin
      check("bus_we", bus.bus_we, exp_we);
      check("bus_addr", bus.bus_addr, exp_addr);
      check("bus_be", bus.bus_be, exp_be);
      check("bus_wdata", bus.bus_wdata, exp_wdata);
    end
    stallCnt += StallM;
    reqCnt += bus.bus_req;
    nsCnt += !StallM;
  end
  function automatic int sizeOf(input logic [2:0] f3, input logic st);
    logic [1:0] lo = f3[1:0];
    if (st) return f3 == 3'd0 ? 0 : f3 == 3'd1 ? 1 : 2;
    return lo == 2'd0 ? 0 : lo == 2'd1 ? 1 : 2;
  endfunction
  function automatic logic [3:0] modelBe(input int sz, input logic [31:0] a);
    if (sz == 0) return 4'b0001 << a[1:0];
    if (sz == 1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction
  function automatic logic [31:0] modelWdata(input int sz, input logic [31:0] wd);
    if (sz == 0) return {24'b0, wd[7:0]} * 32'h01010101;
    if (sz == 1) return {16'b0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction
  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [1:0] lane, input logic [31:0] w);
    logic [31:0] bs = w >> (8 * lane);
    logic [31:0] hs = w >> (16 * lane[1]);
    logic [31:0] b = bs & 32'hFF;
    logic [31:0] h = hs & 32'hFFFF;
    case (f3)
      3'b000: return b >= 32'h80 ? b - 32'h100 : b;
      3'b100: return b;
      3'b001: return h >= 32'h8000 ? h - 32'h10000 : h;
      3'b101: return h;
      default: return w;
    endcase
  endfunction
  task automatic scramble();
    MemReadM = 1'($urandom_range(0, 1));
    MemWriteM = 1'($urandom_range(0, 1));
    Funct3M = 3'($urandom_range(0, 7));
    ALUResultM = $urandom;
    WriteDataM = $urandom;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      MemReadM = 0; MemWriteM = 0; ALUResultM = $urandom;
      exp_req = 0; exp_stall = 0; exp_mis = 0; exp_rd = hold;
      bus.bus_gnt = 0; bus.bus_rvalid = 1'($urandom_range(0, 1)); bus.bus_rdata = $urandom;
      @(posedge CLK); #1;
    end
  endtask
  task automatic runAccess(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int gDly, input int rDly, input logic [31:0] rdata);
    int sz;
    logic mis;
    sz = sizeOf(f3, wr);
    mis = 0;
`ifdef MISALIGN_TRAP_EN
    mis = (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00);
`endif
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    bus.bus_gnt = gDly == 0 && !mis; bus.bus_rvalid = 0;
    exp_req = !mis; exp_stall = 1; exp_mis = 0; exp_rd = hold; exp_we = wr;
    exp_addr = addr & ~32'h3; exp_be = modelBe(sz, addr); exp_wdata = modelWdata(sz, wd);
    @(posedge CLK); #1;
    if (!mis) begin
      for (int i = 1; i <= gDly; i++) begin
        scramble();
        bus.bus_gnt = i == gDly;
        bus.bus_rvalid = !bus.bus_gnt && 1'($urandom_range(0, 1));
        bus.bus_rdata = $urandom;
        @(posedge CLK); #1;
      end
      bus.bus_gnt = 0;
      if (!wr) begin
        exp_req = 0;
        for (int j = 1; j <= rDly; j++) begin
          scramble();
          bus.bus_rvalid = j == rDly;
          bus.bus_rdata = j == rDly ? rdata : $urandom;
          @(posedge CLK); #1;
        end
        hold = modelLoad(f3, addr[1:0], rdata);
      end
    end else hold = 0;
    scramble();
    exp_req = 0; exp_stall = 0; exp_mis = mis; exp_rd = hold;
    bus.bus_rvalid = 1'($urandom_range(0, 1)); bus.bus_rdata = $urandom;
    @(posedge CLK); #1;
    MemReadM = 0; MemWriteM = 0; bus.bus_rvalid = 0; exp_mis = 0; exp_stall = 0;
  endtask
  initial begin
    RST_N = 1; MemReadM = 0; MemWriteM = 0; Funct3M = 0; ALUResultM = 0; WriteDataM = 0;
    bus.bus_gnt = 0; bus.bus_rvalid = 0; bus.bus_rdata = 0;
    hold = 0; exp_req = 0; exp_stall = 0; exp_mis = 0; exp_rd = 0; exp_we = 0;
    exp_addr = 0; exp_be = 0; exp_wdata = 0;
    #2 RST_N = 0;
    #1 chk = 1;
    @(posedge CLK); @(posedge CLK); @(posedge CLK); #2 RST_N = 1;
    @(posedge CLK); #1;
    idle(2);
    stallCnt = 0;
    runAccess(1, 0, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF);
    check("lw stall cycles", stallCnt, 2);
    check("lw data", ReadDataM, 32'hDEADBEEF);
    idle(1);
    runAccess(1, 0, 3'b000, 32'h103, 32'h0, 0, 2, 32'h80FF0000);
    check("lb data", ReadDataM, 32'hFFFFFF80);
    runAccess(1, 0, 3'b100, 32'h103, 32'h0, 1, 1, 32'h80FF0000);
    check("lbu data", ReadDataM, 32'h00000080);
    idle(1);
    stallCnt = 0; reqCnt = 0;
    runAccess(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 3, 1, 32'h0);
    check("sh req cycles", reqCnt, 4);
    check("sh stall cycles", stallCnt, 4);
    idle(1);
    stallCnt = 0; nsCnt = 0;
    runAccess(0, 1, 3'b010, 32'h40, 32'hA5A5A5A5, 0, 1, 32'h0);
    runAccess(1, 0, 3'b010, 32'h44, 32'h0, 0, 1, 32'h13579BDF);
    check("b2b stall cycles", stallCnt, 3);
    check("b2b done cycles", nsCnt, 2);
    idle(1);
    reqCnt = 0;
`ifdef MISALIGN_TRAP_EN
    runAccess(1, 0, 3'b010, 32'h101, 32'h0, 0, 1, 32'h11223344);
    check("misaligned req cycles", reqCnt, 0);
    check("misaligned data", ReadDataM, 32'h0);
`else
    runAccess(1, 0, 3'b010, 32'h101, 32'h0, 0, 1, 32'h11223344);
    check("aligned-forced req cycles", reqCnt, 1);
    check("aligned-forced data", ReadDataM, 32'h11223344);
`endif
    idle(1);
    runAccess(1, 0, 3'b010, 32'h200, 32'h0, 0, 1, 32'h55AA55AA);
    MemReadM = 1; MemWriteM = 0; Funct3M = 3'b010; ALUResultM = 32'h300; WriteDataM = 0;
    bus.bus_gnt = 1;
    exp_req = 1; exp_stall = 1; exp_we = 0; exp_addr = 32'h300; exp_be = 4'hF; exp_wdata = 0; exp_rd = hold;
    @(posedge CLK); #1;
    bus.bus_gnt = 0; exp_req = 0; exp_stall = 1;
    @(negedge CLK); #2;
    RST_N = 0; hold = 0; exp_stall = 0; exp_req = 0; exp_rd = 0;
    #1;
    check("reset bus_req", bus.bus_req, 0);
    check("reset StallM", StallM, 0);
    check("reset ReadDataM", ReadDataM, 32'h0);
    @(posedge CLK); #1;
    bus.bus_rvalid = 1; bus.bus_rdata = 32'hCAFEF00D;
    @(posedge CLK); #1;
    bus.bus_rvalid = 0; MemReadM = 0; RST_N = 1;
    @(posedge CLK); #1;
    bus.bus_rvalid = 1; bus.bus_rdata = 32'hCAFEF00D;
    @(posedge CLK); #1;
    bus.bus_rvalid = 0;
    check("stale rvalid ignored", ReadDataM, 32'h0);
    for (int n = 0; n < 300; n++) begin
      logic [1:0] kind = 2'($urandom_range(1, 3));
      runAccess(kind[0], kind[1], 3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
      idle($urandom_range(0, 2));
    end
    chk = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage load/store unit of the pipelined OTTER core. It sits between the E->M pipeline register and the M->W pipeline register.
- Takes address, store data and funct3 from the M stage.
- Runs a req/gnt/rvalid handshake on the data bus and stalls the pipeline while an access is outstanding.
- Delivers formatted load data as ReadDataM, which the M->W register captures.

Parameters:
XLEN, 32, data and address width; only 32 is supported.
RESET_RDATA, 32'h0, reset and idle value of the read-data hold register.

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
MemReadM  in  1  M-stage instruction is a load
MemWriteM  in  1  M-stage instruction is a store
Funct3M  in  3  load/store size and sign code
ALUResultM  in  XLEN  effective byte address
WriteDataM  in  XLEN  store data (rs2)
bus_req  out  1  request valid
bus_we  out  1  1 = write, 0 = read
bus_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
bus_be  out  4  byte enables
bus_wdata  out  XLEN  lane-replicated store data
bus_gnt  in  1  request accepted this cycle
bus_rvalid  in  1  read data valid
bus_rdata  in  XLEN  read word
ReadDataM  out  XLEN  formatted load result, stable while in DONE
StallM  out  1  hold the F/D/E/M stages
MisalignM  out  1  misaligned-access flag

Behaviour:
- Reset: asynchronous on RST_N=0.
  - state=IDLE; bus_req=0; StallM=0; MisalignM=0; ReadDataM=RESET_RDATA.
- access = MemReadM | MemWriteM. If both are high, treat the access as a store.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - No access: StallM=0, no bus activity, ReadDataM holds its last value.
  - access=1: bus_req=1 and StallM=1, both combinational.
  - gnt=1 on a read -> WAIT_RSP. gnt=1 on a write -> DONE. gnt=0 -> REQ.
- REQ:
  - bus_req, addr, we, be and wdata held stable from registered copies; StallM=1.
  - On gnt, go to WAIT_RSP or DONE as in IDLE.
- WAIT_RSP:
  - StallM=1.
  - On rvalid: capture the formatted bus_rdata into the hold register, then go to DONE.
  - rvalid in the same cycle as gnt is not legal. Response data arrives at the earliest one cycle after gnt.
- DONE:
  - StallM=0, so the pipeline advances this cycle; ReadDataM = hold register.
  - Next state is always IDLE, so the new M-stage instruction is examined one cycle later.
  - A back-to-back access therefore costs one bubble cycle.
- Minimum stall: read = 2 cycles (gnt in IDLE, rvalid the next cycle); write = 1 cycle.
- rvalid seen in IDLE, REQ or DONE is ignored. This includes a stale response after a mid-access reset.
- Load formatting (lane = addr[1:0]):
  - 000 lb: selected byte, sign-extended.
  - 100 lbu: selected byte, zero-extended.
  - 001 lh: half selected by addr[1], sign-extended.
  - 101 lhu: half selected by addr[1], zero-extended.
  - 010 lw and all other codes: full word.
- Store formatting:
  - sb: be = 4'b0001 << lane; wdata = {4{WriteDataM[7:0]}}.
  - sh: be = 4'b0011 << (2*addr[1]); wdata = {2{WriteDataM[15:0]}}.
  - sw and other codes: be = 4'b1111; wdata = WriteDataM.
- Reads drive be with the access size, exactly as for stores.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Misaligned cases are half accesses with addr[0]=1 and word accesses with addr[1:0]!=0.
  - A misaligned access issues no bus_req. IDLE goes directly to DONE, with StallM=1 for that one IDLE cycle.
  - In DONE: MisalignM=1 and ReadDataM=0. MisalignM is high only in that DONE cycle.
- Undefined:
  - MisalignM is tied 0.
  - Low address bits below the access size are ignored, i.e. the access is forced to natural alignment.

Decomposition:
- Package mem_pkg holds:
  - Funct3 localparams: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW.
  - Enum typedef mau_state_t {IDLE, REQ, WAIT_RSP, DONE}.
  - Byte-enable constants BE_BYTE, BE_HALF, BE_WORD.
- One combinational sub-module, load_formatter(funct3, lane, rdata) -> result. It is shared with future cache-refill logic.

Test Plan:
- lw at addr 0x100: gnt in IDLE, rvalid one cycle later with rdata 0xDEADBEEF -> StallM high 2 cycles, DONE ReadDataM=0xDEADBEEF, bus_addr=0x100, be=1111.
- lb at 0x103 with rdata 0x80FF_0000, then lbu at the same address -> ReadDataM 0xFFFFFF80, then 0x00000080.
- sh at 0x202 with WriteDataM 0x1234ABCD and gnt delayed 3 cycles -> bus_req held for 4 cycles with be=1100 and wdata=0xABCDABCD stable throughout, StallM deasserts in DONE.
- RST_N pulled low in WAIT_RSP, then rvalid arrives -> immediate IDLE, bus_req=0, response ignored, ReadDataM=RESET_RDATA.
- Back-to-back sw/lw -> exactly one non-stalled DONE cycle between the two accesses, and the second request starts the cycle after DONE.
- MISALIGN_TRAP_EN defined, lw at 0x101 -> no bus_req, MisalignM=1 for one cycle, ReadDataM=0. Macro undefined -> bus_addr=0x100 and MisalignM=0.
